// File: rtl/rv32_mmio_pkg.sv
// Shared definitions for the RV32 data-side memory subsystem.
//   - MMIO register offsets within the 4 KiB page
//   - STATUS register bit positions
//   - default region bases
//   - region / register decode enums and the offset decoder
package rv32_mmio_pkg;

  localparam logic [11:0] OFF_MTIME_LO    = 12'h000;
  localparam logic [11:0] OFF_MTIME_HI    = 12'h004;
  localparam logic [11:0] OFF_MTIMECMP_LO = 12'h008;
  localparam logic [11:0] OFF_MTIMECMP_HI = 12'h00C;
  localparam logic [11:0] OFF_TXDATA      = 12'h010;
  localparam logic [11:0] OFF_STATUS      = 12'h014;

  localparam int unsigned ST_FULL     = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_COUNT_LO = 2;
  localparam int unsigned ST_COUNT_HI = 7;
  localparam int unsigned ST_BUS_ERR  = 8;
  localparam int unsigned ST_TX_OVF   = 9;

  localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEF_MMIO_BASE = 32'h1000_0000;

  typedef enum logic [1:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_MMIO
  } region_e;

  typedef enum logic [2:0] {
    MREG_MTIME_LO,
    MREG_MTIME_HI,
    MREG_CMP_LO,
    MREG_CMP_HI,
    MREG_TXDATA,
    MREG_STATUS,
    MREG_INVALID
  } mreg_e;

  // Word-aligned page offset to register select.
  function automatic mreg_e decode_off(input logic [11:0] off);
    case (off)
      OFF_MTIME_LO:    return MREG_MTIME_LO;
      OFF_MTIME_HI:    return MREG_MTIME_HI;
      OFF_MTIMECMP_LO: return MREG_CMP_LO;
      OFF_MTIMECMP_HI: return MREG_CMP_HI;
      OFF_TXDATA:      return MREG_TXDATA;
      OFF_STATUS:      return MREG_STATUS;
      default:         return MREG_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/rv32_tx_fifo.sv
// Parameterised synchronous FIFO for the console TX path.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i, din_i  write request and data
//   pop_i          read request (ignored while empty)
//   dout_o         head entry, 0 while empty
//   full_o/empty_o occupancy flags
//   count_o        entries held, 0..DEPTH
//   drop_o         pulse: push rejected (full, no pop this cycle)
module rv32_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // A pop frees the head slot this edge, so a push while full is still
  // accepted when paired with a pop; a pop while empty never happens.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;

  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; dout_o is gated by empty_o instead.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/rv32_dmem_mmio.sv
// Data-side memory subsystem for the single-cycle RV32 core.
// Decodes a word RAM and a 4 KiB MMIO page (64-bit machine timer with
// compare interrupt, console TX FIFO, status). Loads are combinational.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   address             byte address (bits [1:0] ignored)
//   MemRead, MemWrite   load / store strobes
//   wdata, rdata        store data / combinational load data (0 if !MemRead)
//   tx_data, tx_valid   FIFO head and non-empty flag
//   tx_ready            consumer accepts head this cycle
//   timer_irq           registered mtime >= mtimecmp
//   bus_err             sticky unmapped-access flag
module rv32_dmem_mmio
  import rv32_mmio_pkg::*;
#(
  parameter int unsigned    AW         = 32,
  parameter int unsigned    DW         = 32,
  parameter int unsigned    RAM_WORDS  = 1024,
  parameter logic [AW-1:0]  RAM_BASE   = AW'(DEF_RAM_BASE),
  parameter logic [AW-1:0]  MMIO_BASE  = AW'(DEF_MMIO_BASE),
  parameter int unsigned    FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          timer_irq,
  output logic          bus_err
);

  localparam int unsigned IW  = $clog2(RAM_WORDS);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

  logic [DW-1:0]  ram_q [RAM_WORDS];
  logic [IW-1:0]  ram_idx;

  logic [63:0]    mtime_q,    mtime_d;
  logic [63:0]    mtimecmp_q, mtimecmp_d;
  logic           irq_q,      irq_d;
  logic           bus_err_q,  bus_err_d;
  logic           tx_ovf_q,   tx_ovf_d;

  region_e        region;
  mreg_e          mreg;
  logic           mmio_wr;
  logic           push;
  logic           fifo_full, fifo_empty, fifo_drop;
  logic [FCW-1:0] fifo_count;
  logic [31:0]    status_w;
  logic [DW-1:0]  rd_word;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  // RAM base is aligned to its size, so the hit test is a tag compare.
  always_comb begin
    region = RGN_NONE;
    if (address[AW-1:IW+2] == RAM_BASE[AW-1:IW+2])
      region = RGN_RAM;
    else if (address[AW-1:12] == MMIO_BASE[AW-1:12])
      region = RGN_MMIO;
  end

  assign ram_idx = address[IW+1:2];
  assign mreg    = decode_off({address[11:2], 2'b00});
  assign mmio_wr = MemWrite && (region == RGN_MMIO);
  assign push    = mmio_wr && (mreg == MREG_TXDATA);

  always_ff @(posedge clk) begin
    if (MemWrite && region == RGN_RAM) ram_q[ram_idx] <= wdata;
  end

  rv32_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (tx_ready),
    .din_i   (wdata[7:0]),
    .dout_o  (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  assign tx_valid = ~fifo_empty;

  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (mmio_wr && mreg == MREG_CMP_LO) mtimecmp_d[31:0]  = 32'(wdata);
    if (mmio_wr && mreg == MREG_CMP_HI) mtimecmp_d[63:32] = 32'(wdata);
    irq_d      = (mtime_q >= mtimecmp_q);
    tx_ovf_d   = tx_ovf_q | fifo_drop;
    bus_err_d  = bus_err_q;
    if ((MemRead || MemWrite) &&
        (region == RGN_NONE || (region == RGN_MMIO && mreg == MREG_INVALID)))
      bus_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
      bus_err_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
      bus_err_q  <= bus_err_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

  assign timer_irq = irq_q;
  assign bus_err   = bus_err_q;

  always_comb begin
    status_w                          = '0;
    status_w[ST_FULL]                 = fifo_full;
    status_w[ST_EMPTY]                = fifo_empty;
    status_w[ST_COUNT_HI:ST_COUNT_LO] = 6'(fifo_count);
    status_w[ST_BUS_ERR]              = bus_err_q;
    status_w[ST_TX_OVF]               = tx_ovf_q;
  end

  // Reads see pre-edge state, so a simultaneous write returns the old value.
  always_comb begin
    rd_word = '0;
    case (region)
      RGN_RAM: rd_word = ram_q[ram_idx];
      RGN_MMIO: begin
        case (mreg)
          MREG_MTIME_LO: rd_word = DW'(mtime_q[31:0]);
          MREG_MTIME_HI: rd_word = DW'(mtime_q[63:32]);
          MREG_CMP_LO:   rd_word = DW'(mtimecmp_q[31:0]);
          MREG_CMP_HI:   rd_word = DW'(mtimecmp_q[63:32]);
          MREG_STATUS:   rd_word = DW'(status_w);
          default:       rd_word = '0;
        endcase
      end
      default: rd_word = '0;
    endcase
    rdata = MemRead ? rd_word : '0;
  end

endmodule

// File: tb/tb_rv32_dmem_mmio.sv
// Directed self-checking bench for rv32_dmem_mmio.
module tb_rv32_dmem_mmio;

  localparam logic [31:0] MM       = 32'h1000_0000;
  localparam logic [31:0] A_MTLO   = MM + 32'h00;
  localparam logic [31:0] A_MTHI   = MM + 32'h04;
  localparam logic [31:0] A_CMPLO  = MM + 32'h08;
  localparam logic [31:0] A_CMPHI  = MM + 32'h0C;
  localparam logic [31:0] A_TX     = MM + 32'h10;
  localparam logic [31:0] A_STATUS = MM + 32'h14;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        MemRead, MemWrite;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        timer_irq, bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32_dmem_mmio #(
    .AW         (32),
    .DW         (32),
    .RAM_WORDS  (1024),
    .RAM_BASE   (32'h0000_0000),
    .MMIO_BASE  (32'h1000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .wdata     (wdata),
    .rdata     (rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    address  = a;
    wdata    = d;
    MemWrite = 1'b1;
    step();
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    address = a;
    MemRead = 1'b1;
    #1;
    d       = rdata;
    MemRead = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        found;

    reset    = 1'b1;
    address  = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    wdata    = '0;
    tx_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_irq", timer_irq, 0);
    check("rst_bus_err", bus_err, 0);
    bus_read(A_MTLO, rd);   check("rst_mtime_lo", rd, 0);
    bus_read(A_CMPLO, rd);  check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
    bus_read(A_CMPHI, rd);  check("rst_cmp_hi", rd, 32'hFFFF_FFFF);
    bus_read(A_STATUS, rd); check("rst_status", rd, 32'h0000_0002);

    step();
    reset = 1'b0;

    // Timer compare: rises one cycle after mtime reaches 100
    bus_write(A_CMPHI, 32'h0);
    bus_write(A_CMPLO, 32'd100);
    address = A_MTLO;
    MemRead = 1'b1;
    #1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (rdata == 32'd100) found = 1'b1;
      else step();
    end
    check("mtime_reach_100", rdata, 100);
    check("irq_at_100", timer_irq, 0);
    step();
    check("mtime_101", rdata, 101);
    check("irq_rise", timer_irq, 1);
    MemRead = 1'b0;
    bus_write(A_CMPLO, 32'hFFFF_FFFF);
    check("irq_hold_wr_edge", timer_irq, 1);
    step();
    check("irq_fall", timer_irq, 0);

    // RAM
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    bus_read(32'h0000_0012, rd); check("ram_rd_unaligned", rd, 32'hDEAD_BEEF);
    address = 32'h0000_0010;
    #1;
    check("rdata_idle_zero", rdata, 0);
    bus_write(32'h0000_0FFC, 32'hCAFE_F00D);
    bus_read(32'h0000_0FFF, rd); check("ram_last_word", rd, 32'hCAFE_F00D);
    address  = 32'h0000_0010;
    wdata    = 32'h1234_5678;
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    #1;
    check("rdw_old_value", rdata, 32'hDEAD_BEEF);
    step();
    MemWrite = 1'b0;
    #1;
    check("rdw_new_value", rdata, 32'h1234_5678);
    MemRead = 1'b0;

    // Writes to read-only offsets are silently ignored
    bus_write(A_MTLO, 32'h0);
    bus_write(A_STATUS, 32'hFFFF_FFFF);
    check("ro_write_no_err", bus_err, 0);
    bus_read(A_CMPLO, rd); check("cmp_lo_readback", rd, 32'hFFFF_FFFF);
    bus_read(A_TX, rd);    check("txdata_reads_zero", rd, 0);

    // FIFO fill with overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(A_TX, 32'hABCD_0000 | (32'h41 + 32'(i)));
    bus_read(A_STATUS, rd); check("status_full_ovf", rd, 32'h0000_0211);
    check("head_41", tx_data, 8'h41);
    check("valid_full", tx_valid, 1);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", tx_valid, 1);
      check("drain_data", tx_data, 8'h41 + 8'(i));
      step();
    end
    check("drained_valid", tx_valid, 0);
    check("drained_data", tx_data, 0);

    // Push while full with a concurrent pop
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(A_TX, 32'h61 + 32'(i));
    address  = A_TX;
    wdata    = 32'h55;
    MemWrite = 1'b1;
    tx_ready = 1'b1;
    step();
    MemWrite = 1'b0;
    bus_read(A_STATUS, rd); check("status_full_pushpop", rd, 32'h0000_0211);
    check("pp_head0", tx_data, 8'h62);
    step(); check("pp_head1", tx_data, 8'h63);
    step(); check("pp_head2", tx_data, 8'h64);
    step(); check("pp_head3_55", tx_data, 8'h55);
    step(); check("pp_empty", tx_valid, 0);

    // Push and pop on empty: push kept, no pop
    bus_read(A_STATUS, rd); check("status_empty_ovf", rd, 32'h0000_0202);
    bus_write(A_TX, 32'h77);
    check("empty_pp_valid", tx_valid, 1);
    check("empty_pp_data", tx_data, 8'h77);
    step();
    check("empty_pp_drained", tx_valid, 0);
    tx_ready = 1'b0;

    // mtime wrap, via backdoor
    bus_write(A_CMPHI, 32'hFFFF_FFFF);
    force dut.mtime_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.mtime_q;
    bus_read(A_MTLO, rd); check("wrap_lo_fe", rd, 32'hFFFF_FFFE);
    bus_read(A_MTHI, rd); check("wrap_hi_ff", rd, 32'hFFFF_FFFF);
    check("wrap_irq_fe", timer_irq, 0);
    step();
    bus_read(A_MTLO, rd); check("wrap_lo_ff", rd, 32'hFFFF_FFFF);
    check("wrap_irq_ff", timer_irq, 0);
    step();
    bus_read(A_MTLO, rd); check("wrap_lo_0", rd, 0);
    bus_read(A_MTHI, rd); check("wrap_hi_0", rd, 0);
    check("wrap_irq_at_0", timer_irq, 1);
    step();
    bus_read(A_MTLO, rd); check("wrap_lo_1", rd, 1);
    check("wrap_irq_at_1", timer_irq, 0);

    // Unlisted MMIO offset
    address = MM + 32'h20;
    MemRead = 1'b1;
    #1;
    check("mmio_hole_rdata", rdata, 0);
    check("mmio_hole_err_pre", bus_err, 0);
    step();
    MemRead = 1'b0;
    check("mmio_hole_err", bus_err, 1);

    // Asynchronous reset mid-stream, with a push pending
    bus_write(A_TX, 32'h99);
    check("pre_rst_valid", tx_valid, 1);
    address  = A_TX;
    wdata    = 32'hAA;
    MemWrite = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_bus_err", bus_err, 0);
    check("async_rst_valid", tx_valid, 0);
    check("async_rst_irq", timer_irq, 0);
    step();
    MemWrite = 1'b0;
    check("rst_push_dropped", tx_valid, 0);
    bus_read(A_MTLO, rd); check("async_rst_mtime", rd, 0);
    step();
    reset = 1'b0;

    bus_read(32'h0000_0010, rd); check("ram_survives_rst", rd, 32'h1234_5678);
    bus_read(A_STATUS, rd);      check("status_after_rst", rd, 32'h0000_0002);

    // Just past RAM, then outside both regions
    address = 32'h0000_1000;
    MemRead = 1'b1;
    #1;
    check("ram_end_rdata", rdata, 0);
    step();
    MemRead = 1'b0;
    check("ram_end_err", bus_err, 1);
    address = 32'h2000_0000;
    MemRead = 1'b1;
    #1;
    check("unmapped_rdata", rdata, 0);
    step();
    MemRead = 1'b0;
    step();
    check("err_sticky", bus_err, 1);
    bus_read(A_STATUS, rd); check("status_bus_err", rd, 32'h0000_0102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
